// File: rtl/ripple_monitor_pkg.sv
// Shared types and default constants for the ripple-counter monitor.
package ripple_monitor_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR  = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_SETTLE = 2'd3
   } mon_state_e;

   localparam int unsigned DEF_WIDTH      = 4;
   localparam int unsigned DEF_LIMIT      = 9;
   localparam int unsigned DEF_SETTLE     = 2;
   localparam int unsigned DEF_CLR_CYCLES = 2;

   // Bits needed to hold a counter that reaches n.
   function automatic int unsigned cnt_bits(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ripple_monitor_sync2.sv
// Two-flop synchroniser bringing the asynchronous ripple-counter bus into clk.
module ripple_monitor_sync2 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             preset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;

   // Metastability-settling pipeline; decisions downstream use s2 only.
   always_ff @(posedge clk or posedge preset) begin
      if (preset) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/ripple_monitor.sv
// Settles, sequence-checks and wraps an asynchronous JK ripple counter at LIMIT,
// presenting a clean value/valid/terminal-count view to the clk domain.
module ripple_monitor
   import ripple_monitor_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned LIMIT      = DEF_LIMIT,
   parameter int unsigned SETTLE     = DEF_SETTLE,
   parameter int unsigned CLR_CYCLES = DEF_CLR_CYCLES
) (
   input  logic             clk,
   input  logic             preset,
   input  logic             enable,
   input  logic [WIDTH-1:0] q_in,
   output logic             cnt_enable,
   output logic             cnt_clear,
   output logic [WIDTH-1:0] value,
   output logic             valid,
   output logic             tc,
   output logic [7:0]       wraps,
   output logic             error
);

   localparam int unsigned SW = cnt_bits(SETTLE);
   localparam int unsigned CW = cnt_bits(CLR_CYCLES);
   localparam logic [WIDTH-1:0] LIMIT_V    = WIDTH'(LIMIT);
   localparam logic [WIDTH-1:0] ONE_V      = WIDTH'(1);
   localparam logic [SW-1:0]    SETTLE_V   = SW'(SETTLE);
   localparam logic [SW-1:0]    SETTLE_M1  = SW'(SETTLE - 1);
   localparam logic [SW-1:0]    STAB_ONE   = SW'(1);
   localparam logic [CW-1:0]    CLR_LAST   = CW'(CLR_CYCLES - 1);
   localparam logic [CW-1:0]    CLR_ONE    = CW'(1);

   mon_state_e       state_q, state_d;
   logic [CW-1:0]    clr_cnt_q, clr_cnt_d;
   logic [SW-1:0]    stab_cnt_q, stab_cnt_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             valid_q, valid_d;
   logic             tc_q, tc_d;
   logic [7:0]       wraps_q, wraps_d;
   logic             error_q, error_d;
   logic             cnt_enable_q, cnt_enable_d;
   logic             cnt_clear_q, cnt_clear_d;

   logic [WIDTH-1:0] sync_s;
   logic             clr_done_s;
   logic             drain_done_s;
   logic             accept_s;
   logic             at_limit_s;

   ripple_monitor_sync2 #(.WIDTH(WIDTH)) u_sync (
      .clk    (clk),
      .preset (preset),
      .d_i    (q_in),
      .q_o    (sync_s)
   );

   assign clr_done_s   = (clr_cnt_q == CLR_LAST);
   assign drain_done_s = (sync_s == '0) && (stab_cnt_q == SETTLE_M1);
   assign accept_s     = (state_q == ST_SETTLE) && (sync_s == cand_q) && (stab_cnt_q >= SETTLE_V);
   assign at_limit_s   = (cand_q == LIMIT_V);

   // State and datapath registers; preset holds the counter cleared.
   always_ff @(posedge clk or posedge preset) begin
      if (preset) begin
         state_q      <= ST_CLEAR;
         clr_cnt_q    <= '0;
         stab_cnt_q   <= '0;
         cand_q       <= '0;
         value_q      <= '0;
         valid_q      <= 1'b0;
         tc_q         <= 1'b0;
         wraps_q      <= 8'd0;
         error_q      <= 1'b0;
         cnt_enable_q <= 1'b0;
         cnt_clear_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         stab_cnt_q   <= stab_cnt_d;
         cand_q       <= cand_d;
         value_q      <= value_d;
         valid_q      <= valid_d;
         tc_q         <= tc_d;
         wraps_q      <= wraps_d;
         error_q      <= error_d;
         cnt_enable_q <= cnt_enable_d;
         cnt_clear_q  <= cnt_clear_d;
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLEAR:  if (clr_done_s) state_d = ST_DRAIN; else state_d = ST_CLEAR;
         ST_DRAIN:  if (drain_done_s) state_d = ST_WAIT; else state_d = ST_DRAIN;
         ST_WAIT:   if (sync_s != value_q) state_d = ST_SETTLE; else state_d = ST_WAIT;
         ST_SETTLE: begin
            if (accept_s)                state_d = at_limit_s ? ST_CLEAR : ST_WAIT;
            else if (sync_s == value_q)  state_d = ST_WAIT;
            else                         state_d = ST_SETTLE;
         end
         default:   state_d = ST_CLEAR;
      endcase
   end

   // Datapath and registered-output next values.
   always_comb begin
      clr_cnt_d    = clr_cnt_q;
      stab_cnt_d   = stab_cnt_q;
      cand_d       = cand_q;
      value_d      = value_q;
      valid_d      = 1'b0;
      tc_d         = 1'b0;
      wraps_d      = wraps_q;
      error_d      = error_q;
      cnt_enable_d = cnt_enable_q;
      cnt_clear_d  = cnt_clear_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_enable_d = 1'b0;
            if (clr_done_s) begin
               cnt_clear_d = 1'b0;
               clr_cnt_d   = '0;
               stab_cnt_d  = '0;
            end else begin
               cnt_clear_d = 1'b1;
               clr_cnt_d   = clr_cnt_q + CLR_ONE;
            end
         end
         ST_DRAIN: begin
            cnt_enable_d = 1'b0;
            if (drain_done_s) begin
               value_d    = '0;
               stab_cnt_d = '0;
            end else if (sync_s == '0) begin
               stab_cnt_d = stab_cnt_q + STAB_ONE;
            end else begin
               stab_cnt_d = '0;
            end
         end
         ST_WAIT: begin
            cnt_enable_d = enable;
            if (sync_s != value_q) begin
               cand_d     = sync_s;
               stab_cnt_d = STAB_ONE;
            end else begin
               stab_cnt_d = stab_cnt_q;
            end
         end
         ST_SETTLE: begin
            cnt_enable_d = enable;
            if (accept_s) begin
               value_d = cand_q;
               valid_d = 1'b1;
               if (cand_q != value_q + ONE_V) error_d = 1'b1; else error_d = error_q;
               // Terminal count: stop the counter and re-run the clear sequence.
               if (at_limit_s) begin
                  tc_d         = 1'b1;
                  wraps_d      = wraps_q + 8'd1;
                  cnt_enable_d = 1'b0;
                  cnt_clear_d  = 1'b1;
                  clr_cnt_d    = '0;
               end else begin
                  tc_d = 1'b0;
               end
            end else if (sync_s == value_q) begin
               stab_cnt_d = stab_cnt_q;
            end else if (sync_s != cand_q) begin
               cand_d     = sync_s;
               stab_cnt_d = STAB_ONE;
            end else if (stab_cnt_q < SETTLE_V) begin
               stab_cnt_d = stab_cnt_q + STAB_ONE;
            end else begin
               stab_cnt_d = stab_cnt_q;
            end
         end
         default: begin
            cnt_enable_d = 1'b0;
            cnt_clear_d  = 1'b1;
         end
      endcase
   end

   assign cnt_enable = cnt_enable_q;
   assign cnt_clear  = cnt_clear_q;
   assign value      = value_q;
   assign valid      = valid_q;
   assign tc         = tc_q;
   assign wraps      = wraps_q;
   assign error      = error_q;

endmodule

// File: tb/tb_ripple_monitor.sv
// Bench for ripple_monitor driven by a behavioural 4-bit JK ripple counter,
// with an optional override of q_in for glitch and out-of-sequence stimulus.
module tb_ripple_monitor;
   import ripple_monitor_pkg::*;

   localparam int LIM = 9;
   localparam int SET = 2;

   logic       clk = 1'b0;
   logic       cnt_clk = 1'b0;
   logic       preset = 1'b0;
   logic       enable = 1'b0;
   logic       force_en = 1'b0;
   logic [3:0] force_val = 4'd0;
   logic [3:0] rc = 4'd0;
   logic [3:0] ctr_q, q_in;
   logic       cnt_enable, cnt_clear, valid, tc, error;
   logic [3:0] value;
   logic [7:0] wraps;

   int tests = 0;
   int fails = 0;

   logic [3:0] exp_vals [0:63];
   int         wr_idx = 0;
   int         rd_idx = 0;
   logic [3:0] m_last = 4'd0;
   logic       m_err = 1'b0;
   logic [7:0] m_wraps = 8'd0;

   ripple_monitor dut (
      .clk        (clk),
      .preset     (preset),
      .enable     (enable),
      .q_in       (q_in),
      .cnt_enable (cnt_enable),
      .cnt_clear  (cnt_clear),
      .value      (value),
      .valid      (valid),
      .tc         (tc),
      .wraps      (wraps),
      .error      (error)
   );

   always #5 clk = ~clk;
   always #40 cnt_clk = ~cnt_clk;

   assign ctr_q = cnt_clear ? 4'd0 : rc;
   assign q_in  = force_en ? force_val : ctr_q;

   // Ripple counter: each stage toggles 3 ns after the previous stage falls.
   initial begin
      forever begin
         @(negedge cnt_clk or posedge cnt_clear);
         if (cnt_clear) begin
            rc = 4'd0;
         end else if (cnt_enable) begin
            for (int b = 0; b < 4; b++) begin
               #3;
               rc[b] = ~rc[b];
               if (rc[b]) break;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] v);
      exp_vals[wr_idx] = v;
      wr_idx++;
   endtask

   task automatic wait_val(input logic [3:0] v, input int budget);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (valid && value == v) begin
            seen = 1'b1;
            break;
         end
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL wait_value_%0d: no strobe within %0d cycles", v, budget);
      end
   endtask

   task automatic wait_any(input int budget, output logic [3:0] got);
      bit seen;
      seen = 1'b0;
      got = 4'd15;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (valid) begin
            seen = 1'b1;
            got = value;
            break;
         end
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL wait_any: no strobe within %0d cycles", budget);
      end
   endtask

   // Forces a new stable q_in value at a negedge and measures strobe latency.
   task automatic step(input logic [3:0] v, output int lat);
      push(v);
      force_val = v;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (valid) begin
            lat = k;
            break;
         end
      end
      tests++;
      if (lat == 0) begin
         fails++;
         $display("FAIL step_%0d: no strobe within 12 cycles", v);
      end
      repeat (2) @(negedge clk);
   endtask

   // Scoreboard: every strobe must match the next expected settled value.
   initial begin
      logic [3:0] exp_v;
      logic [3:0] nxt;
      forever begin
         @(negedge clk);
         if (preset) begin
            rd_idx  = wr_idx;
            m_last  = 4'd0;
            m_err   = 1'b0;
            m_wraps = 8'd0;
         end else begin
            if (valid) begin
               if (rd_idx >= wr_idx) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_valid: got value %0d with nothing expected", value);
               end else begin
                  exp_v = exp_vals[rd_idx];
                  rd_idx++;
                  check("value", {28'd0, value}, {28'd0, exp_v});
                  check("tc_on_valid", {31'd0, tc}, {31'd0, (exp_v == 4'(LIM))});
                  nxt = m_last + 4'd1;
                  if (exp_v != nxt) m_err = 1'b1;
                  if (exp_v == 4'(LIM)) begin
                     m_wraps = m_wraps + 8'd1;
                     m_last  = 4'd0;
                  end else begin
                     m_last = exp_v;
                  end
               end
            end else begin
               check("tc_without_valid", {31'd0, tc}, 32'd0);
            end
            check("error", {31'd0, error}, {31'd0, m_err});
            check("wraps", {24'd0, wraps}, {24'd0, m_wraps});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         lat;
      int         vcnt;
      logic [3:0] got;
      logic [3:0] gseq [4];
      gseq = '{4'd6, 4'd4, 4'd0, 4'd8};

      // Reset and clear sequence
      #2;
      preset = 1'b1;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_value", {28'd0, value}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_tc", {31'd0, tc}, 32'd0);
      check("rst_wraps", {24'd0, wraps}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_cnt_enable", {31'd0, cnt_enable}, 32'd0);
      check("rst_cnt_clear", {31'd0, cnt_clear}, 32'd1);
      preset = 1'b0;
      @(negedge clk);
      check("clear_hold", {31'd0, cnt_clear}, 32'd1);
      for (int i = 1; i <= LIM; i++) push(4'(i));
      push(4'd1); push(4'd2); push(4'd3);
      @(negedge clk);
      check("clear_release", {31'd0, cnt_clear}, 32'd0);
      check("enable_in_clear", {31'd0, cnt_enable}, 32'd0);
      repeat (2) @(negedge clk);
      check("enable_in_drain", {31'd0, cnt_enable}, 32'd0);
      check("drain_value", {28'd0, value}, 32'd0);
      @(negedge clk);
      check("enable_after_wait", {31'd0, cnt_enable}, 32'd1);

      // Free run to terminal count and beyond
      wait_val(4'd9, 150);
      check("tc_at_limit", {31'd0, tc}, 32'd1);
      check("clear_at_tc", {31'd0, cnt_clear}, 32'd1);
      @(negedge clk);
      check("clear_at_tc_2", {31'd0, cnt_clear}, 32'd1);
      @(negedge clk);
      check("clear_drop_after_tc", {31'd0, cnt_clear}, 32'd0);
      repeat (2) @(negedge clk);
      check("value_after_wrap", {28'd0, value}, 32'd0);
      wait_val(4'd3, 100);
      enable = 1'b0;
      check("wraps_after_run", {24'd0, wraps}, 32'd1);
      check("error_after_run", {31'd0, error}, 32'd0);

      // Enable drop and resume
      @(negedge clk);
      check("enable_drop", {31'd0, cnt_enable}, 32'd0);
      vcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid) vcnt++;
      end
      check("frozen_no_valid", 32'(vcnt), 32'd0);
      check("frozen_value", {28'd0, value}, 32'd3);
      push(4'd4); push(4'd5);
      enable = 1'b1;
      wait_val(4'd5, 100);
      enable = 1'b0;
      repeat (4) @(negedge clk);

      // Preset while settling a new value
      force_val = 4'd5;
      force_en  = 1'b1;
      repeat (3) @(negedge clk);
      force_val = 4'd6;
      repeat (3) @(negedge clk);
      check("pre_preset_valid", {31'd0, valid}, 32'd0);
      check("pre_preset_value", {28'd0, value}, 32'd5);
      preset = 1'b1;
      #1;
      check("preset_cnt_clear", {31'd0, cnt_clear}, 32'd1);
      check("preset_value", {28'd0, value}, 32'd0);
      check("preset_wraps", {24'd0, wraps}, 32'd0);
      check("preset_error", {31'd0, error}, 32'd0);
      check("preset_cnt_enable", {31'd0, cnt_enable}, 32'd0);
      repeat (3) @(negedge clk);
      force_en = 1'b0;
      enable   = 1'b1;
      preset   = 1'b0;
      @(negedge clk);
      for (int i = 1; i <= 7; i++) push(4'(i));
      wait_any(60, got);
      check("restart_first", {28'd0, got}, 32'd1);
      wait_val(4'd7, 120);
      enable = 1'b0;
      repeat (4) @(negedge clk);

      // Ripple intermediates 0111 -> 0110 -> 0100 -> 0000 -> 1000
      force_val = 4'd7;
      force_en  = 1'b1;
      repeat (3) @(negedge clk);
      push(4'd8);
      vcnt = 0;
      for (int i = 0; i < 4; i++) begin
         force_val = gseq[i];
         @(negedge clk);
         if (valid) vcnt++;
      end
      repeat (10) begin
         @(negedge clk);
         if (valid) vcnt++;
      end
      check("glitch_one_valid", 32'(vcnt), 32'd1);
      check("glitch_value", {28'd0, value}, 32'd8);
      check("glitch_error", {31'd0, error}, 32'd0);

      // Out-of-sequence value sets sticky error
      preset    = 1'b1;
      force_val = 4'd0;
      repeat (3) @(negedge clk);
      preset = 1'b0;
      repeat (8) @(negedge clk);
      check("idle_cnt_enable", {31'd0, cnt_enable}, 32'd0);
      step(4'd1, lat);
      check("latency", 32'(lat), 32'(SET + 3));
      step(4'd2, lat);
      step(4'd3, lat);
      check("pre_skip_error", {31'd0, error}, 32'd0);
      step(4'd5, lat);
      check("skip_value", {28'd0, value}, 32'd5);
      check("skip_error", {31'd0, error}, 32'd1);
      step(4'd6, lat);
      step(4'd7, lat);
      check("error_sticky", {31'd0, error}, 32'd1);
      check("all_expected_seen", 32'(rd_idx), 32'(wr_idx));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
